core_seq: RTL and testbench
===========================

// Module: core_seq
// PURPOSE
//  Multi-cycle sequencer for the RV32I core around the control decoder.
//  Shares one memory port between instruction fetch and load/store data access.
//  Steps each instruction through FETCH -> EXEC -> [MEM] -> WB and raises the register strobes.
//  Adds a memory-timeout watchdog, a retired-instruction counter and a sticky trap/halt.
// PARAMETERS
//  MEM_TIMEOUT  255  cycles without mem_ack before trap; legal range 1..255 (8-bit counter)
//  CNT_W        32   width of instret
// PORTS
//  clk            in   1      core clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  run            in   1      1 = fetch new instructions; sampled in IDLE and WB
//  dec_mem_we     in   1      decoder: instruction is a store
//  dec_mem2reg    in   3      decoder writeback select; 3'b001 = load
//  dec_no_wb      in   1      decoder: no rd write (branch/store)
//  dec_illegal    in   1      decoder: opcode not recognised
//  mem_ack        in   1      memory completes the current request
//  mem_err        in   1      bus error; valid only with mem_ack
//  mem_req        out  1      memory request
//  mem_wr         out  1      1 = write request (store)
//  addr_sel       out  1      0 = PC (fetch), 1 = ALU result (data)
//  ir_we          out  1      capture instruction register
//  mdr_we         out  1      capture load data register
//  rf_we          out  1      register-file write enable
//  pc_we          out  1      PC update enable
//  halted         out  1      in TRAP
//  trap_cause     out  2      00 none, 01 bus error, 10 timeout, 11 illegal
//  instret        out  CNT_W  retired-instruction count
//  state          out  3      current FSM state (debug)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all outputs 0, timer=0.
//  IDLE: strobes 0. If run=1, go to FETCH on the next edge.
//  FETCH: mem_req=1, mem_wr=0, addr_sel=0.
//   - mem_ack & !mem_err: ir_we=1 (same cycle, Mealy), go to EXEC.
//   - mem_ack & mem_err: go to TRAP with cause 01; ir_we stays 0.
//  EXEC: one cycle. Decoder inputs are valid here because the IR is registered.
//   - dec_illegal: go to TRAP, cause 11.
//   - else load (dec_mem2reg==001) or dec_mem_we: go to MEM.
//   - else: go to WB.
//  MEM: mem_req=1, mem_wr=dec_mem_we, addr_sel=1.
//   - ack & !err: mdr_we=1 only for loads (Mealy), go to WB.
//   - ack & err: go to TRAP, cause 01.
//  WB: one cycle. rf_we=!dec_no_wb, pc_we=1, instret+=1 (wraps at 2^CNT_W).
//   Next state is FETCH if run=1, else IDLE.
//  TRAP: halted=1, all strobes 0, trap_cause held. Exit only through rst_n.
//  Handshake rules:
//   - mem_req, mem_wr and addr_sel stay stable until mem_ack or timeout.
//   - Back-to-back requests get at least one cycle of mem_req=0 between them (EXEC/WB).
//   - mem_ack outside FETCH/MEM is ignored. mem_err without mem_ack is ignored.
//  Timer:
//   - Clears on entry to FETCH/MEM, increments each waiting cycle.
//   - Reaching MEM_TIMEOUT with no ack: go to TRAP, cause 10; mem_req drops next cycle.
//   - mem_ack in the same cycle as expiry: ack wins.
//  run=0 mid-instruction: the instruction still completes through WB, then IDLE.
//  pc_we, rf_we and halted are Moore outputs decoded from registered state;
//   ir_we and mdr_we are Mealy on mem_ack. No combinational path from dec_* to mem_req.
// STRUCTURE
//  core_pkg: state encodings (IDLE, FETCH, EXEC, MEM, WB, TRAP), TRAP_* cause codes, M2R_LOAD=3'b001.
//  Sub-module mem_timer: clear / enable / expire counter (MEM_TIMEOUT, async reset).
//  Top level: FSM, output decode, instret register.
// TESTING
//  1. ADD, ack one cycle after req -> states IDLE,FETCH,EXEC,WB; rf_we=1,pc_we=1 in WB; instret 0->1.
//  2. LW with ack delayed 3 cycles -> mem_req held 4 cycles with addr_sel=1, mdr_we pulse on ack, rf_we in WB.
//  3. SW -> mem_wr=1 in MEM, rf_we=0, pc_we=1; BEQ -> no MEM state, rf_we=0.
//  4. MEM_TIMEOUT=4, no ack in FETCH -> TRAP after 4 cycles, trap_cause=10, halted=1, mem_req=0.
//  5. Illegal opcode -> TRAP cause 11 from EXEC; mem_err with ack in MEM -> cause 01; rst_n low clears both.
//  6. run dropped in EXEC -> WB completes, then IDLE; instret preset 32'hFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer.
package core_seq_pkg;

  // Sequencer states; the encoding is also exported on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_TRAP  = 3'd5
  } state_e;

  // Trap cause codes reported on trap_cause_o.
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_BUS     = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b11;

  // Decoder writeback select value that marks a load.
  localparam logic [2:0] M2R_LOAD = 3'b001;

  // True in the states that own the memory port and wait for mem_ack.
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/core_seq_if.sv
// Shared memory port between the sequencer (master) and the memory (slave).
interface core_seq_if;
  logic mem_req;
  logic mem_wr;
  logic addr_sel;
  logic mem_ack;
  logic mem_err;

  modport master (
    output mem_req,
    output mem_wr,
    output addr_sel,
    input  mem_ack,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_wr,
    input  addr_sel,
    output mem_ack,
    output mem_err
  );
endinterface

// File: rtl/core_seq_mem_timer.sv
// Memory-wait watchdog: counts waiting cycles and flags the last allowed one.
module core_seq_mem_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // The last waiting cycle is the one where the count reaches MEM_TIMEOUT-1.
  localparam logic [7:0] LAST_CNT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt_q;

  // Wait counter: cleared outside a request, holds once it reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (clr_i) begin
      cnt_q <= 8'd0;
    end else if (en_i && (cnt_q != LAST_CNT)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/core_seq.sv
// Multi-cycle sequencer: FETCH -> EXEC -> [MEM] -> WB with watchdog,
// retired-instruction counter and sticky trap.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  core_seq_if.master       bus,
  input  logic             run_i,
  input  logic             dec_mem_we_i,
  input  logic [2:0]       dec_mem2reg_i,
  input  logic             dec_no_wb_i,
  input  logic             dec_illegal_i,
  output logic             ir_we_o,
  output logic             mdr_we_o,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic             halted_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [2:0]       state_o
);

  state_e             state_q;
  logic [1:0]         cause_q;
  logic               store_q;   // decoded in EXEC, drives mem_wr in MEM
  logic               load_q;    // decoded in EXEC, gates mdr_we in MEM
  logic               wb_q;      // decoded in EXEC, drives rf_we in WB
  logic [CNT_W-1:0]   instret_q;

  logic               waiting_s;
  logic               ack_ok_s;
  logic               ack_err_s;
  logic               expire_s;

  assign waiting_s = is_mem_state(state_q);
  assign ack_ok_s  = bus.mem_ack && !bus.mem_err;
  assign ack_err_s = bus.mem_ack && bus.mem_err;

  core_seq_mem_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!waiting_s),
    .en_i     (waiting_s),
    .expire_o (expire_s)
  );

  // Sequencer FSM with trap cause, latched decode and retired-instruction count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cause_q   <= TRAP_NONE;
      store_q   <= 1'b0;
      load_q    <= 1'b0;
      wb_q      <= 1'b0;
      instret_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_i) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          // An ack in the expiry cycle still completes the fetch.
          if (ack_err_s) begin
            state_q <= ST_TRAP;
            cause_q <= TRAP_BUS;
          end else if (ack_ok_s) begin
            state_q <= ST_EXEC;
          end else if (expire_s) begin
            state_q <= ST_TRAP;
            cause_q <= TRAP_TIMEOUT;
          end
        end
        ST_EXEC: begin
          store_q <= dec_mem_we_i;
          load_q  <= (dec_mem2reg_i == M2R_LOAD);
          wb_q    <= !dec_no_wb_i;
          if (dec_illegal_i) begin
            state_q <= ST_TRAP;
            cause_q <= TRAP_ILLEGAL;
          end else if ((dec_mem2reg_i == M2R_LOAD) || dec_mem_we_i) begin
            state_q <= ST_MEM;
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (ack_err_s) begin
            state_q <= ST_TRAP;
            cause_q <= TRAP_BUS;
          end else if (ack_ok_s) begin
            state_q <= ST_WB;
          end else if (expire_s) begin
            state_q <= ST_TRAP;
            cause_q <= TRAP_TIMEOUT;
          end
        end
        ST_WB: begin
          instret_q <= instret_q + CNT_W'(1);
          state_q   <= run_i ? ST_FETCH : ST_IDLE;
        end
        ST_TRAP: begin
          state_q <= ST_TRAP;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory port is decoded from registered state only, so it is glitch-free
  // and independent of the decoder inputs.
  assign bus.mem_req  = waiting_s;
  assign bus.mem_wr   = (state_q == ST_MEM) && store_q;
  assign bus.addr_sel = (state_q == ST_MEM);

  // Capture strobes follow mem_ack in the same cycle.
  assign ir_we_o  = (state_q == ST_FETCH) && ack_ok_s;
  assign mdr_we_o = (state_q == ST_MEM) && ack_ok_s && load_q;

  assign rf_we_o      = (state_q == ST_WB) && wb_q;
  assign pc_we_o      = (state_q == ST_WB);
  assign halted_o     = (state_q == ST_TRAP);
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_core_seq.sv
// Randomized self-checking bench for core_seq. A cycle-by-cycle program of
// stimulus and expected outputs is built from the instruction-level rules,
// then played against the DUT and compared every cycle.
module tb_core_seq;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_i = 1'b0;
  logic       dec_mem_we_i = 1'b0;
  logic [2:0] dec_mem2reg_i = 3'd0;
  logic       dec_no_wb_i = 1'b0;
  logic       dec_illegal_i = 1'b0;
  logic       ir_we_o, mdr_we_o, rf_we_o, pc_we_o, halted_o;
  logic [1:0] trap_cause_o;
  logic [3:0] instret_o;
  logic [2:0] state_o;

  core_seq_if bus();

  core_seq #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .run_i         (run_i),
    .dec_mem_we_i  (dec_mem_we_i),
    .dec_mem2reg_i (dec_mem2reg_i),
    .dec_no_wb_i   (dec_no_wb_i),
    .dec_illegal_i (dec_illegal_i),
    .ir_we_o       (ir_we_o),
    .mdr_we_o      (mdr_we_o),
    .rf_we_o       (rf_we_o),
    .pc_we_o       (pc_we_o),
    .halted_o      (halted_o),
    .trap_cause_o  (trap_cause_o),
    .instret_o     (instret_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  // exp layout: [12:10] state, [9] req, [8] wr, [7] sel, [6] ir_we,
  // [5] mdr_we, [4] rf_we, [3] pc_we, [2] halted, [1:0] cause
  typedef struct packed {
    logic        rst;
    logic        run;
    logic        ack;
    logic        err;
    logic        we;
    logic [2:0]  m2r;
    logic        nowb;
    logic        ill;
    logic [12:0] exp;
    logic [3:0]  icnt;
  } cyc_t;

  cyc_t prog[$];

  int total = 0;
  int bad = 0;

  // instruction-level model state
  int         m_instret = 0;
  logic [1:0] m_cause = 2'b00;
  bit         m_idle = 1'b1;
  bit         allow_idle = 1'b0;
  logic       cur_we = 1'b0;
  logic [2:0] cur_m2r = 3'd0;
  logic       cur_nowb = 1'b0;
  logic       cur_ill = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic [2:0] st, input logic run, input logic ack, input logic err,
                     input logic req, input logic wr, input logic sel, input logic irwe,
                     input logic mdrwe, input logic rfwe, input logic pcwe);
    cyc_t c;
    c.rst  = 1'b1;
    c.run  = run;
    c.ack  = ack;
    c.err  = err;
    c.we   = cur_we;
    c.m2r  = cur_m2r;
    c.nowb = cur_nowb;
    c.ill  = cur_ill;
    c.exp  = {st, req, wr, sel, irwe, mdrwe, rfwe, pcwe, (st == 3'd5), m_cause};
    c.icnt = 4'(m_instret);
    prog.push_back(c);
  endtask

  task automatic do_reset(input int n);
    cyc_t c;
    m_instret = 0;
    m_cause   = 2'b00;
    m_idle    = 1'b1;
    for (int i = 0; i < n; i++) begin
      c = '0;
      c.rst = 1'b0;
      c.run = rb();
      c.ack = rb();
      c.err = rb();
      prog.push_back(c);
    end
  endtask

  task automatic trap(input logic [1:0] cause);
    m_cause = cause;
    for (int i = 0; i < 3; i++)
      add(3'd5, rb(), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(2);
  endtask

  // One memory transfer: ack arrives after 'delay' waiting cycles, or never
  // if delay >= TMO. res: 0 done, 1 bus error, 2 timeout.
  task automatic mem_phase(input bit fetch, input int delay, input bit err_on_ack,
                           input bit load, output int res);
    res = 2;
    for (int c = 0; c < TMO; c++) begin
      logic a;
      a = (c == delay);
      add(fetch ? 3'd1 : 3'd3, rb(), a, a ? err_on_ack : rb(), 1'b1,
          fetch ? 1'b0 : cur_we, !fetch, fetch && a && !err_on_ack,
          !fetch && a && !err_on_ack && load, 1'b0, 1'b0);
      if (a) begin
        res = err_on_ack ? 1 : 0;
        return;
      end
    end
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 branch, 4 illegal
  task automatic instr(input int kind, input int fdel, input bit ferr,
                       input int mdel, input bit merr, input bit run_after);
    int res;
    logic [2:0] other;
    bit is_load, is_store;
    other = 3'($urandom_range(0, 7));
    if (other == 3'b001) other = 3'b000;
    cur_ill  = (kind == 4);
    cur_we   = (kind == 2) || ((kind == 4) && rb());
    cur_m2r  = (kind == 1) ? 3'b001 : other;
    cur_nowb = (kind == 2) || (kind == 3) || ((kind == 4) && rb());
    is_load  = (cur_m2r == 3'b001);
    is_store = cur_we;
    if (m_idle) begin
      if (allow_idle) begin
        int k;
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++)
          add(3'd0, 1'b0, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      add(3'd0, 1'b1, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    mem_phase(1'b1, fdel, ferr, 1'b0, res);
    if (res == 1) begin trap(2'b01); return; end
    if (res == 2) begin trap(2'b10); return; end
    add(3'd2, rb(), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (cur_ill) begin trap(2'b11); return; end
    if (is_load || is_store) begin
      mem_phase(1'b0, mdel, merr, is_load, res);
      if (res == 1) begin trap(2'b01); return; end
      if (res == 2) begin trap(2'b10); return; end
    end
    add(3'd4, run_after, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !cur_nowb, 1'b1);
    m_instret = (m_instret + 1) % 16;
    m_idle = !run_after;
  endtask

  initial begin
    int b;
    int n;
    int last;
    bus.mem_ack = 1'b0;
    bus.mem_err = 1'b0;

    // ---------------- build the program ----------------
    do_reset(2);

    // ADD, immediate ack, run dropped at WB
    b = prog.size();
    instr(0, 0, 1'b0, 0, 1'b0, 1'b0);
    check("pin_add_len", prog.size() - b, 4);
    check("pin_add_states", {prog[b].exp[12:10], prog[b+1].exp[12:10],
                             prog[b+2].exp[12:10], prog[b+3].exp[12:10]}, 12'b000_001_010_100);
    check("pin_add_wb", prog[b+3].exp[4:3], 2'b11);
    check("pin_add_cnt", prog[b+3].icnt, 4'd0);

    // LW, ack on the 4th MEM cycle (same cycle as expiry: ack wins)
    b = prog.size();
    instr(1, 0, 1'b0, 3, 1'b0, 1'b1);
    n = 0;
    last = b;
    for (int i = b; i < prog.size(); i++)
      if (prog[i].exp[12:10] == 3'd3) begin n++; last = i; end
    check("pin_lw_mem_cycles", n, 4);
    check("pin_lw_mdr", {prog[last].exp[9], prog[last].exp[7], prog[last].exp[5]}, 3'b111);
    check("pin_lw_wb_rf", prog[prog.size()-1].exp[4:3], 2'b11);

    // SW, BEQ, then an ALU op that stops the core
    instr(2, 1, 1'b0, 2, 1'b0, 1'b1);
    instr(3, 0, 1'b0, 0, 1'b0, 1'b1);
    instr(0, 2, 1'b0, 0, 1'b0, 1'b0);

    // retired counter wrap (4-bit counter here)
    do_reset(1);
    for (int i = 0; i < 16; i++) instr(0, $urandom_range(0, 1), 1'b0, 0, 1'b0, 1'b1);
    check("pin_wrap_model", m_instret, 0);
    check("pin_wrap_last", prog[prog.size()-1].icnt, 4'hF);
    instr(0, 0, 1'b0, 0, 1'b0, 1'b0);

    // fetch timeout
    b = prog.size();
    instr(0, TMO, 1'b0, 0, 1'b0, 1'b1);
    n = 0;
    last = b;
    for (int i = b; i < prog.size(); i++) begin
      if (prog[i].exp[12:10] == 3'd5) begin last = i; break; end
      if (prog[i].exp[12:10] == 3'd1) n++;
    end
    check("pin_tmo_fetch_cycles", n, TMO);
    check("pin_tmo_trap", {prog[last].exp[9], prog[last].exp[2], prog[last].exp[1:0]}, 4'b0110);

    // illegal opcode, load bus error, fetch bus error
    instr(4, 0, 1'b0, 0, 1'b0, 1'b1);
    instr(1, 1, 1'b0, 1, 1'b1, 1'b1);
    instr(0, 2, 1'b1, 0, 1'b0, 1'b1);

    // randomized traffic
    allow_idle = 1'b1;
    for (int i = 0; i < 80; i++) begin
      int kind, fd, md;
      kind = ($urandom_range(0, 19) == 0) ? 4 : $urandom_range(0, 3);
      fd = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, TMO - 1);
      md = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, TMO - 1);
      instr(kind, fd, ($urandom_range(0, 11) == 0), md, ($urandom_range(0, 11) == 0), rb());
    end

    // ---------------- play and compare every cycle ----------------
    for (int i = 0; i < prog.size(); i++) begin
      cyc_t c;
      logic [12:0] got;
      c = prog[i];
      @(posedge clk);
      #1;
      rst_n         = c.rst;
      run_i         = c.run;
      bus.mem_ack   = c.ack;
      bus.mem_err   = c.err;
      dec_mem_we_i  = c.we;
      dec_mem2reg_i = c.m2r;
      dec_no_wb_i   = c.nowb;
      dec_illegal_i = c.ill;
      @(negedge clk);
      got = {state_o, bus.mem_req, bus.mem_wr, bus.addr_sel, ir_we_o, mdr_we_o,
             rf_we_o, pc_we_o, halted_o, trap_cause_o};
      check($sformatf("cyc%0d_outputs", i), got, c.exp);
      check($sformatf("cyc%0d_instret", i), instret_o, c.icnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
